// File: rtl/adc_sampler_fenics_if.sv
// Valid/ready stream carrying ADC codes from the sampler FIFO to the HPS reader.
interface adc_sampler_fenics_if #(
   parameter int ADC_BITS = 12
) ();
   logic [ADC_BITS-1:0] out_data;
   logic                out_valid;
   logic                out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/adc_sampler_fenics.sv
// FENICS front-end ADC model: gain shift, pedestal, clip to ADC range, decimate at a
// selectable phase and buffer codes in a first-word-fall-through FIFO for the HPS reader.
module adc_sampler_fenics #(
   parameter int BITS_IN  = 51,
   parameter int SHIFT    = 22,
   parameter int PEDESTAL = 256,
   parameter int ADC_BITS = 12,
   parameter int DECIM    = 4,
   parameter int PH_BITS  = 2,
   parameter int FIFO_LOG = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [PH_BITS-1:0]        phase,
   input  logic signed [BITS_IN-1:0] in,
   adc_sampler_fenics_if.master      out_bus,
   output logic [FIFO_LOG:0]         fifo_level,
   output logic                      sat_flag,
   output logic [15:0]               drop_count
);

   localparam int DEPTH = 1 << FIFO_LOG;
   localparam int SW    = BITS_IN + 1;
   localparam int LW    = FIFO_LOG + 1;
   localparam logic signed [SW-1:0] PED_S    = SW'(PEDESTAL);
   localparam logic signed [SW-1:0] MAX_S    = SW'((1 << ADC_BITS) - 1);
   localparam logic [PH_BITS-1:0]   CNT_LAST = PH_BITS'(DECIM - 1);
   localparam logic [LW-1:0]        LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0]        LVL_ONE  = LW'(1);

   // Returns {clipped, code}: negative sums floor at 0, large sums pin to full scale.
   function automatic logic [ADC_BITS:0] clip_code(input logic signed [SW-1:0] s);
      logic [ADC_BITS:0] r;
      if (s[SW-1]) begin
         r = {1'b1, {ADC_BITS{1'b0}}};
      end else if (s > MAX_S) begin
         r = {1'b1, {ADC_BITS{1'b1}}};
      end else begin
         r = {1'b0, s[ADC_BITS-1:0]};
      end
      return r;
   endfunction

   logic [PH_BITS-1:0]        cnt_r;
   logic                      strobe_s;
   logic signed [BITS_IN-1:0] in_r;
   logic                      v1_r;
   logic signed [SW-1:0]      ext_s;
   logic signed [SW-1:0]      scaled_s;
   logic [ADC_BITS:0]         clip_s;
   logic [ADC_BITS-1:0]       code_r;
   logic                      v2_r;
   logic                      sat_r;

   logic [ADC_BITS-1:0]       mem [DEPTH];
   logic [LW-1:0]             wr_ptr_r;
   logic [LW-1:0]             rd_ptr_r;
   logic [FIFO_LOG-1:0]       rd_idx_next_s;
   logic [LW-1:0]             level_r;
   logic [LW-1:0]             level_n_s;
   logic [ADC_BITS-1:0]       head_r;
   logic [ADC_BITS-1:0]       head_n_s;
   logic                      valid_r;
   logic [15:0]               drop_r;
   logic                      pop_s;
   logic                      push_s;
   logic                      drop_s;
   logic                      full_s;

   // Strobe decode and the scale/offset arithmetic at BITS_IN+1 bits so the pedestal cannot wrap.
   always_comb begin
      strobe_s = enable && (cnt_r == phase);
      ext_s    = {in_r[BITS_IN-1], in_r};
      scaled_s = (ext_s >>> SHIFT) + PED_S;
      clip_s   = clip_code(scaled_s);
   end

   // Decimation counter and the capture / conversion pipeline stages.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r  <= {PH_BITS{1'b0}};
         in_r   <= {BITS_IN{1'b0}};
         v1_r   <= 1'b0;
         code_r <= {ADC_BITS{1'b0}};
         v2_r   <= 1'b0;
         sat_r  <= 1'b0;
      end else begin
         if (!enable || (cnt_r == CNT_LAST)) begin
            cnt_r <= {PH_BITS{1'b0}};
         end else begin
            cnt_r <= cnt_r + 1'b1;
         end
         if (strobe_s) begin
            in_r <= in;
         end
         v1_r   <= strobe_s;
         code_r <= clip_s[ADC_BITS-1:0];
         v2_r   <= v1_r;
         if (v1_r && clip_s[ADC_BITS]) begin
            sat_r <= 1'b1;
         end
      end
   end

   // A push on a full FIFO is still taken when the head leaves on the same edge.
   always_comb begin
      pop_s         = valid_r && out_bus.out_ready;
      full_s        = (level_r == LVL_FULL);
      push_s        = v2_r && (!full_s || pop_s);
      drop_s        = v2_r && full_s && !pop_s;
      rd_idx_next_s = rd_ptr_r[FIFO_LOG-1:0] + 1'b1;
      level_n_s     = level_r + {{FIFO_LOG{1'b0}}, push_s} - {{FIFO_LOG{1'b0}}, pop_s};
   end

   // Next head: the incoming code when it becomes the only entry, else the following slot on a pop.
   always_comb begin
      head_n_s = head_r;
      if (push_s && ((level_r == {LW{1'b0}}) || (pop_s && (level_r == LVL_ONE)))) begin
         head_n_s = code_r;
      end else if (pop_s && (level_r > LVL_ONE)) begin
         head_n_s = mem[rd_idx_next_s];
      end else begin
         head_n_s = head_r;
      end
   end

   // FIFO storage; contents need no reset because pointers define what is live.
   always_ff @(posedge clock) begin
      if (!reset && push_s) begin
         mem[wr_ptr_r[FIFO_LOG-1:0]] <= code_r;
      end
   end

   // FIFO pointers, occupancy, registered head and the saturating drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= {LW{1'b0}};
         rd_ptr_r <= {LW{1'b0}};
         level_r  <= {LW{1'b0}};
         head_r   <= {ADC_BITS{1'b0}};
         valid_r  <= 1'b0;
         drop_r   <= 16'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         level_r <= level_n_s;
         head_r  <= head_n_s;
         valid_r <= (level_n_s != {LW{1'b0}});
         if (drop_s && (drop_r != 16'hFFFF)) begin
            drop_r <= drop_r + 16'd1;
         end
      end
   end

   assign out_bus.out_data  = head_r;
   assign out_bus.out_valid = valid_r;
   assign fifo_level        = level_r;
   assign sat_flag          = sat_r;
   assign drop_count        = drop_r;

endmodule
